// File: rtl/nway_fifo.sv
// Parametrised N-lane valid/ready FIFO with fill level, almost-full and sticky protocol-error flags.
// Lane 0 is the oldest entry on both sides; up to Lanes entries enter and leave per cycle.
module nway_fifo #(
    parameter int Depth     = 8,
    parameter int Width     = 32,
    parameter int Lanes     = 4,
    parameter int PplRead   = 0,
    parameter int WrThrough = 0,
    parameter int AFullThr  = 6
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic [Lanes-1:0]           wr_valid_i,
    input  logic [Lanes*Width-1:0]     wr_data_i,
    output logic [Lanes-1:0]           wr_rdy_o,
    input  logic [Lanes-1:0]           rd_rdy_i,
    output logic [Lanes-1:0]           rd_valid_o,
    output logic [Lanes*Width-1:0]     rd_data_o,
    output logic [$clog2(Depth):0]     level_o,
    output logic                       afull_o,
    output logic                       err_o
);

    localparam int LW = $clog2(Depth) + 1;
    localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int SW = LW + 1;
    localparam logic [LW-1:0] IdxMask = LW'(Depth - 1);

    logic [Width-1:0] mem [Depth];

    logic [LW-1:0] wr_ptr_q;
    logic [LW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic          afull_q;
    logic          err_q;

    logic [SW-1:0]    free_q;
    logic [SW-1:0]    fill_q;
    logic [Lanes-1:0] stored_valid;
    logic [SW-1:0]    n_r_stored;
    logic [SW-1:0]    wr_room;
    logic [SW-1:0]    rd_avail;
    logic [SW-1:0]    n_w;
    logic [SW-1:0]    n_r;
    logic [SW-1:0]    level_nxt;
    logic             proto_err;

    function automatic logic [SW-1:0] lead_ones(input logic [Lanes-1:0] v);
        logic [SW-1:0] n;
        logic          run;
        n   = '0;
        run = 1'b1;
        for (int k = 0; k < Lanes; k++) begin
            run = run & v[k];
            if (run) n = n + SW'(1);
        end
        return n;
    endfunction

    function automatic logic is_therm(input logic [Lanes-1:0] v);
        logic [Lanes:0] ext;
        ext = {1'b0, v};
        return ((ext & (ext + 1'b1)) == '0);
    endfunction

    function automatic logic [AW-1:0] slot(input logic [LW-1:0] ptr, input int k);
        logic [LW-1:0] sum;
        sum = ptr + LW'(k);
        return AW'(sum & IdxMask);
    endfunction

    // Write readiness under PplRead only credits reads of already-stored entries,
    // which keeps it independent of the write-through bypass and loop-free.
    always_comb begin
        free_q       = SW'(Depth) - SW'(level_q);
        fill_q       = SW'(level_q);
        stored_valid = '0;
        wr_rdy_o     = '0;
        rd_valid_o   = '0;
        rd_data_o    = '0;

        for (int k = 0; k < Lanes; k++) stored_valid[k] = (fill_q > SW'(k));
        n_r_stored = lead_ones(stored_valid & rd_rdy_i);

        wr_room = (PplRead != 0) ? (free_q + n_r_stored) : free_q;
        for (int k = 0; k < Lanes; k++) wr_rdy_o[k] = (wr_room > SW'(k));
        n_w = lead_ones(wr_valid_i & wr_rdy_o);

        rd_avail = (WrThrough != 0) ? (fill_q + n_w) : fill_q;
        for (int k = 0; k < Lanes; k++) rd_valid_o[k] = (rd_avail > SW'(k));
        n_r = lead_ones(rd_valid_o & rd_rdy_i);

        for (int k = 0; k < Lanes; k++) begin
            if (SW'(k) < fill_q) begin
                rd_data_o[k*Width +: Width] = mem[slot(rd_ptr_q, k)];
            end else if (rd_valid_o[k]) begin
                for (int j = 0; j < Lanes; j++) begin
                    if ((SW'(k) - fill_q) == SW'(j))
                        rd_data_o[k*Width +: Width] = wr_data_i[j*Width +: Width];
                end
            end
        end

        level_nxt = fill_q + n_w - n_r;
        proto_err = !is_therm(wr_valid_i) || !is_therm(rd_rdy_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            afull_q  <= 1'b0;
            err_q    <= 1'b0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            afull_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_q + LW'(n_w);
            rd_ptr_q <= rd_ptr_q + LW'(n_r);
            level_q  <= LW'(level_nxt);
            afull_q  <= (level_nxt >= SW'(AFullThr));
            err_q    <= err_q | proto_err;
        end
    end

    // Storage has no reset; bypassed entries are written too so the pointers stay aligned.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !flush_i) begin
            for (int j = 0; j < Lanes; j++) begin
                if (SW'(j) < n_w)
                    mem[slot(wr_ptr_q, j)] <= wr_data_i[j*Width +: Width];
            end
        end
    end

    assign level_o = level_q;
    assign afull_o = afull_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_nway_fifo.sv
// Self-checking bench for nway_fifo: table of control vectors plus a data scoreboard on the
// default configuration, and hand sequences for PplRead, WrThrough and asynchronous reset.
module tb_nway_fifo;

    localparam int Lanes = 4;
    localparam int Width = 32;
    localparam int Depth = 8;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   flush;
    logic [Lanes-1:0]       wr_valid;
    logic [Lanes*Width-1:0] wr_data;
    logic [Lanes-1:0]       rd_rdy;

    logic [Lanes-1:0]       b_wr_rdy, p_wr_rdy, w_wr_rdy;
    logic [Lanes-1:0]       b_rd_valid, p_rd_valid, w_rd_valid;
    logic [Lanes*Width-1:0] b_rd_data, p_rd_data, w_rd_data;
    logic [3:0]             b_level, p_level, w_level;
    logic                   b_afull, p_afull, w_afull;
    logic                   b_err, p_err, w_err;

    always #5 clk = ~clk;

    nway_fifo #(.Depth(Depth), .Width(Width), .Lanes(Lanes), .PplRead(0), .WrThrough(0), .AFullThr(6)) u_base (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_valid_i(wr_valid), .wr_data_i(wr_data),
        .wr_rdy_o(b_wr_rdy), .rd_rdy_i(rd_rdy), .rd_valid_o(b_rd_valid), .rd_data_o(b_rd_data),
        .level_o(b_level), .afull_o(b_afull), .err_o(b_err)
    );

    nway_fifo #(.Depth(Depth), .Width(Width), .Lanes(Lanes), .PplRead(1), .WrThrough(0), .AFullThr(6)) u_ppl (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_valid_i(wr_valid), .wr_data_i(wr_data),
        .wr_rdy_o(p_wr_rdy), .rd_rdy_i(rd_rdy), .rd_valid_o(p_rd_valid), .rd_data_o(p_rd_data),
        .level_o(p_level), .afull_o(p_afull), .err_o(p_err)
    );

    nway_fifo #(.Depth(Depth), .Width(Width), .Lanes(Lanes), .PplRead(0), .WrThrough(1), .AFullThr(6)) u_wt (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .wr_valid_i(wr_valid), .wr_data_i(wr_data),
        .wr_rdy_o(w_wr_rdy), .rd_rdy_i(rd_rdy), .rd_valid_o(w_rd_valid), .rd_data_o(w_rd_data),
        .level_o(w_level), .afull_o(w_afull), .err_o(w_err)
    );

    typedef struct {
        logic [3:0] wv;
        logic [3:0] rr;
        logic       fl;
        logic [3:0] exp_wr_rdy;
        logic [3:0] exp_rd_valid;
        logic [3:0] exp_level;
        logic       exp_afull;
        logic       exp_err;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb[$];
    logic [31:0] data_ctr;
    int          n_vec;
    int          n_miss;

    function automatic void add_vec(input logic [3:0] wv, input logic [3:0] rr, input logic fl,
                                    input logic [3:0] ewr, input logic [3:0] erv,
                                    input logic [3:0] elvl, input logic eaf, input logic eerr);
        vec_t v;
        v.wv = wv; v.rr = rr; v.fl = fl;
        v.exp_wr_rdy = ewr; v.exp_rd_valid = erv;
        v.exp_level = elvl; v.exp_afull = eaf; v.exp_err = eerr;
        vecs.push_back(v);
    endfunction

    function automatic int lead(input logic [3:0] v);
        int n = 0;
        while (n < 4 && v[n]) n++;
        return n;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic set_lanes(input logic [31:0] base);
        for (int k = 0; k < Lanes; k++) wr_data[k*Width +: Width] = base + 32'(k);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        flush    = 1'b0;
        wr_valid = '0;
        rd_rdy   = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One table row: drive at the falling edge, check handshakes and read data before the
    // rising edge, then update the scoreboard and check the registered status after it.
    task automatic apply_stimulus(input vec_t v, input int idx);
        int nw;
        int nr;
        @(negedge clk);
        wr_valid = v.wv;
        rd_rdy   = v.rr;
        flush    = v.fl;
        set_lanes(data_ctr);
        #1;
        check_output($sformatf("v%0d wr_rdy", idx), 32'(b_wr_rdy), 32'(v.exp_wr_rdy));
        check_output($sformatf("v%0d rd_valid", idx), 32'(b_rd_valid), 32'(v.exp_rd_valid));
        for (int k = 0; k < Lanes; k++) begin
            if (!v.exp_rd_valid[k]) begin
                check_output($sformatf("v%0d lane%0d idle data", idx, k), b_rd_data[k*Width +: Width], 32'h0);
            end else if (k < sb.size()) begin
                check_output($sformatf("v%0d lane%0d data", idx, k), b_rd_data[k*Width +: Width], sb[k]);
            end else begin
                n_vec++;
                n_miss++;
                $display("[TB] FAIL v%0d lane%0d data: got %h, required none (scoreboard empty)",
                         idx, k, b_rd_data[k*Width +: Width]);
            end
        end
        nw = lead(v.wv & v.exp_wr_rdy);
        nr = lead(v.rr & v.exp_rd_valid);
        @(posedge clk);
        #1;
        if (v.fl) begin
            sb.delete();
        end else begin
            for (int i = 0; i < nr; i++) if (sb.size() > 0) void'(sb.pop_front());
            for (int j = 0; j < nw; j++) sb.push_back(data_ctr + 32'(j));
            data_ctr = data_ctr + 32'(nw);
        end
        check_output($sformatf("v%0d level", idx), 32'(b_level), 32'(v.exp_level));
        check_output($sformatf("v%0d afull", idx), 32'(b_afull), 32'(v.exp_afull));
        check_output($sformatf("v%0d err", idx), 32'(b_err), 32'(v.exp_err));
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached before end of test");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        wr_valid = '0;
        rd_rdy   = '0;
        wr_data  = '0;
        data_ctr = 32'd0;
        n_vec    = 0;
        n_miss   = 0;

        // Post-reset, fill to full, then read 2 to land on the almost-full threshold.
        add_vec(4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'd4, 1'b0, 1'b0);
        add_vec(4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b1111, 4'd4, 1'b0, 1'b0);
        add_vec(4'b1111, 4'b0000, 1'b0, 4'b1111, 4'b1111, 4'd8, 1'b1, 1'b0);
        add_vec(4'b1111, 4'b0000, 1'b0, 4'b0000, 4'b1111, 4'd8, 1'b1, 1'b0);
        add_vec(4'b0000, 4'b0011, 1'b0, 4'b0000, 4'b1111, 4'd6, 1'b1, 1'b0);
        // Offer 3 writes and 4 reads for 10 cycles across the pointer wrap.
        add_vec(4'b0111, 4'b1111, 1'b0, 4'b0011, 4'b1111, 4'd4, 1'b0, 1'b0);
        add_vec(4'b0111, 4'b1111, 1'b0, 4'b1111, 4'b1111, 4'd3, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++)
            add_vec(4'b0111, 4'b1111, 1'b0, 4'b1111, 4'b0111, 4'd3, 1'b0, 1'b0);
        // Gapped write, sticky error, flush, gapped read.
        add_vec(4'b0101, 4'b0000, 1'b0, 4'b1111, 4'b0111, 4'd4, 1'b0, 1'b1);
        add_vec(4'b0011, 4'b0000, 1'b0, 4'b1111, 4'b1111, 4'd6, 1'b1, 1'b1);
        add_vec(4'b0000, 4'b0001, 1'b0, 4'b0011, 4'b1111, 4'd5, 1'b0, 1'b1);
        add_vec(4'b1111, 4'b1111, 1'b1, 4'b0111, 4'b1111, 4'd0, 1'b0, 1'b0);
        add_vec(4'b0000, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'd0, 1'b0, 1'b0);
        add_vec(4'b0011, 4'b0000, 1'b0, 4'b1111, 4'b0000, 4'd2, 1'b0, 1'b0);
        add_vec(4'b0000, 4'b0110, 1'b0, 4'b1111, 4'b0011, 4'd2, 1'b0, 1'b1);
        add_vec(4'b0000, 4'b1111, 1'b0, 4'b1111, 4'b0011, 4'd0, 1'b0, 1'b1);

        do_reset();
        #1;
        check_output("reset level", 32'(b_level), 32'd0);
        check_output("reset wr_rdy", 32'(b_wr_rdy), 32'hF);
        check_output("reset rd_valid", 32'(b_rd_valid), 32'h0);
        check_output("reset afull", 32'(b_afull), 32'd0);
        check_output("reset err", 32'(b_err), 32'd0);

        for (int i = 0; i < vecs.size(); i++) apply_stimulus(vecs[i], i);

        // Asynchronous reset in the middle of a cycle with err set and entries stored.
        @(negedge clk);
        wr_valid = 4'b1111;
        rd_rdy   = 4'b0000;
        set_lanes(32'h0000_0100);
        @(posedge clk);
        #1;
        check_output("pre-reset level", 32'(b_level), 32'd4);
        #2;
        rst = 1'b1;
        #1;
        check_output("async reset level", 32'(b_level), 32'd0);
        check_output("async reset err", 32'(b_err), 32'd0);
        check_output("async reset rd_valid", 32'(b_rd_valid), 32'h0);
        check_output("async reset wr_rdy", 32'(b_wr_rdy), 32'hF);
        @(negedge clk);
        rst      = 1'b0;
        wr_valid = '0;

        // PplRead: full FIFO accepts a write sized by this cycle's reads.
        do_reset();
        wr_valid = 4'b1111;
        set_lanes(32'd0);
        @(negedge clk);
        set_lanes(32'd4);
        @(posedge clk);
        #1;
        check_output("ppl full level", 32'(p_level), 32'd8);
        check_output("ppl full wr_rdy", 32'(p_wr_rdy), 32'h0);
        check_output("ppl full afull", 32'(p_afull), 32'd1);
        @(negedge clk);
        wr_valid = 4'b0000;
        rd_rdy   = 4'b0011;
        #1;
        check_output("ppl wr_rdy from reads", 32'(p_wr_rdy), 32'h3);
        check_output("ppl head lane0", p_rd_data[0 +: Width], 32'd0);
        check_output("ppl head lane1", p_rd_data[Width +: Width], 32'd1);
        wr_valid = 4'b0011;
        set_lanes(32'd100);
        #1;
        check_output("ppl wr_rdy with write", 32'(p_wr_rdy), 32'h3);
        @(posedge clk);
        #1;
        check_output("ppl level after swap", 32'(p_level), 32'd8);
        @(negedge clk);
        wr_valid = '0;
        rd_rdy   = '0;
        #1;
        check_output("ppl new head", p_rd_data[0 +: Width], 32'd2);
        check_output("ppl wr_rdy idle", 32'(p_wr_rdy), 32'h0);

        // WrThrough: empty FIFO forwards writes to reads in the same cycle.
        do_reset();
        wr_valid = 4'b0111;
        rd_rdy   = 4'b0011;
        set_lanes(32'hA000_0001);
        #1;
        check_output("wt rd_valid", 32'(w_rd_valid), 32'h7);
        check_output("wt lane0", w_rd_data[0 +: Width], 32'hA000_0001);
        check_output("wt lane1", w_rd_data[Width +: Width], 32'hA000_0002);
        @(posedge clk);
        #1;
        check_output("wt level", 32'(w_level), 32'd1);
        @(negedge clk);
        wr_valid = '0;
        rd_rdy   = '0;
        #1;
        check_output("wt rd_valid after", 32'(w_rd_valid), 32'h1);
        check_output("wt next head", w_rd_data[0 +: Width], 32'hA000_0003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
